hazard_controller: RTL and testbench

Pipeline hazard and wait-state controller for the five-stage MIPS pipeline: computes forwarding selects, load-use and branch stalls, and E-stage flush, and sequences multi-cycle data-memory accesses by freezing the F/D/E/M pipeline registers and injecting W bubbles. It sits beside the data path, consumes its register-address and control taps, and drives every stall, flush and forward input of the data path.

---
 rtl/mips_pkg.sv | 19 +
 rtl/forward_unit.sv | 42 ++++
 rtl/hazard_controller.sv | 152 +++++++++++++++
 tb/tb_hazard_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forwarding selects,
// wait-state FSM encoding and the register-match helper.
package mips_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hz_state_e;

  // $0 is hard-wired, so it never forms a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding selects for the decode (branch compare) and
// execute (ALU operand) stages.
module forward_unit
  import mips_pkg::*;
(
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [4:0] Rs_E,
  input  logic [4:0] Rt_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  output logic       forwardA_D,
  output logic       forwardB_D,
  output logic [1:0] forwardA_E,
  output logic [1:0] forwardB_E
);

  assign forwardA_D = RegWrite_M && reg_match(WriteReg_M, Rs_D);
  assign forwardB_D = RegWrite_M && reg_match(WriteReg_M, Rt_D);

  // M holds the younger result, so it wins over W.
  always_comb begin
    forwardA_E = FWD_RF;
    if (RegWrite_M && reg_match(WriteReg_M, Rs_E)) begin
      forwardA_E = FWD_M;
    end else if (RegWrite_W && reg_match(WriteReg_W, Rs_E)) begin
      forwardA_E = FWD_W;
    end
  end

  always_comb begin
    forwardB_E = FWD_RF;
    if (RegWrite_M && reg_match(WriteReg_M, Rt_E)) begin
      forwardB_E = FWD_M;
    end else if (RegWrite_W && reg_match(WriteReg_W, Rt_E)) begin
      forwardB_E = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard and wait-state controller for the five-stage MIPS pipeline: forwarding,
// load-use/branch stalls, and multi-cycle data-memory sequencing.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rs_E,
  input  logic [4:0]       Rt_E,
  input  logic [4:0]       writeReg_E,
  input  logic [4:0]       WriteReg_M,
  input  logic [4:0]       WriteReg_W,
  input  logic             RegWrite_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             MemtoReg_E,
  input  logic             MemtoReg_M,
  input  logic             MemWrite_M,
  input  logic             branch_D,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_E,
  output logic             flush_W,
  output logic             forwardA_D,
  output logic             forwardB_D,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output hz_state_e        dbg_state
);

  localparam bit WAIT_EN = (MEM_WAIT > 0);
  localparam int WCNT_W  = WAIT_EN ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WAIT_EN ? WCNT_W'(MEM_WAIT - 1) : '0;

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cycles_q;

  logic       lwstall, branchstall, hazard_stall, mem_op_M, mem_stall;
  logic       fa_d, fb_d;
  logic [1:0] fa_e, fb_e;

  forward_unit u_forward_unit (
    .Rs_D       (Rs_D),
    .Rt_D       (Rt_D),
    .Rs_E       (Rs_E),
    .Rt_E       (Rt_E),
    .WriteReg_M (WriteReg_M),
    .WriteReg_W (WriteReg_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .forwardA_D (fa_d),
    .forwardB_D (fb_d),
    .forwardA_E (fa_e),
    .forwardB_E (fb_e)
  );

  assign lwstall = MemtoReg_E && (reg_match(Rt_E, Rs_D) || reg_match(Rt_E, Rt_D));

  assign branchstall = branch_D &&
    ((RegWrite_E && (reg_match(writeReg_E, Rs_D) || reg_match(writeReg_E, Rt_D))) ||
     (MemtoReg_M && (reg_match(WriteReg_M, Rs_D) || reg_match(WriteReg_M, Rt_D))));

  assign hazard_stall = lwstall || branchstall;
  assign mem_op_M     = MemtoReg_M || MemWrite_M;

  // The entry cycle already stalls, so WAIT only needs MEM_WAIT-1 more.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (WAIT_EN && mem_op_M) begin
          state_d   = ST_WAIT;
          wcnt_d    = WCNT_INIT;
          mem_stall = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d    = wcnt_q - WCNT_W'(1);
          mem_stall = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Memory wait dominates: the whole front of the pipe freezes and W gets bubbles.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_E  = 1'b0;
    flush_W  = 1'b0;
    mem_busy = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        stall_M  = 1'b1;
        flush_W  = 1'b1;
        mem_busy = 1'b1;
      end else begin
        stall_F = hazard_stall;
        stall_D = hazard_stall;
        flush_E = hazard_stall;
      end
    end
  end

  assign forwardA_D = reset && fa_d;
  assign forwardB_D = reset && fb_d;
  assign forwardA_E = reset ? fa_e : FWD_RF;
  assign forwardB_E = reset ? fb_e : FWD_RF;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else if (stall_F && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MEM_WAIT=2 and a narrow stall
// counter so saturation is reachable in a few cycles.
module tb_hazard_controller;
  import mips_pkg::*;

  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, WriteReg_M, WriteReg_W;
  logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M, MemWrite_M, branch_D;
  logic stall_F, stall_D, stall_E, stall_M, flush_E, flush_W;
  logic forwardA_D, forwardB_D, mem_busy;
  logic [1:0] forwardA_E, forwardB_E;
  logic [CNT_W-1:0] stall_cycles;
  hz_state_e dbg_state;

  int checks   = 0;
  int failures = 0;

  hazard_controller #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs_D         (Rs_D),
    .Rt_D         (Rt_D),
    .Rs_E         (Rs_E),
    .Rt_E         (Rt_E),
    .writeReg_E   (writeReg_E),
    .WriteReg_M   (WriteReg_M),
    .WriteReg_W   (WriteReg_W),
    .RegWrite_E   (RegWrite_E),
    .RegWrite_M   (RegWrite_M),
    .RegWrite_W   (RegWrite_W),
    .MemtoReg_E   (MemtoReg_E),
    .MemtoReg_M   (MemtoReg_M),
    .MemWrite_M   (MemWrite_M),
    .branch_D     (branch_D),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .stall_M      (stall_M),
    .flush_E      (flush_E),
    .flush_W      (flush_W),
    .forwardA_D   (forwardA_D),
    .forwardB_D   (forwardB_D),
    .forwardA_E   (forwardA_E),
    .forwardB_E   (forwardB_E),
    .mem_busy     (mem_busy),
    .stall_cycles (stall_cycles),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs_D = '0; Rt_D = '0; Rs_E = '0; Rt_E = '0;
    writeReg_E = '0; WriteReg_M = '0; WriteReg_W = '0;
    RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    MemtoReg_E = 1'b0; MemtoReg_M = 1'b0; MemWrite_M = 1'b0; branch_D = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed {stall_F, stall_D, stall_E, stall_M, flush_E, flush_W, mem_busy}
  function automatic logic [6:0] ctl();
    return {stall_F, stall_D, stall_E, stall_M, flush_E, flush_W, mem_busy};
  endfunction

  logic pat [6];

  initial begin
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b0;
    clear_inputs();
    // Inputs that would forward and stall if reset were not held
    RegWrite_M = 1'b1; WriteReg_M = 5'd3; Rs_E = 5'd3;
    MemtoReg_E = 1'b1; Rt_E = 5'd5; Rt_D = 5'd5; MemWrite_M = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_fwdA_E", 32'(forwardA_E), 32'(FWD_RF));
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Execute-stage forwarding, M priority over W, $0 never forwards
    tick();
    RegWrite_M = 1'b1; WriteReg_M = 5'd3; RegWrite_W = 1'b1; WriteReg_W = 5'd3; Rs_E = 5'd3;
    #1;
    chk("fwdA_E_M", 32'(forwardA_E), 32'(FWD_M));
    chk("fwdB_E_none", 32'(forwardB_E), 32'(FWD_RF));
    RegWrite_M = 1'b0;
    #1;
    chk("fwdA_E_W", 32'(forwardA_E), 32'(FWD_W));
    Rs_E = 5'd0; WriteReg_M = 5'd0; RegWrite_M = 1'b1; WriteReg_W = 5'd0;
    Rt_E = 5'd9; WriteReg_W = 5'd9;
    #1;
    chk("fwdA_E_r0", 32'(forwardA_E), 32'(FWD_RF));
    chk("fwdB_E_W", 32'(forwardB_E), 32'(FWD_W));
    chk("fwd_no_stall", 32'(ctl()), 32'h0);

    // Load-use stall, one cycle
    tick();
    clear_inputs();
    MemtoReg_E = 1'b1; Rt_E = 5'd5; Rt_D = 5'd5; RegWrite_E = 1'b1; writeReg_E = 5'd5;
    #1;
    chk("lw_ctl", 32'(ctl()), 32'b1100100);
    tick();
    clear_inputs();
    #1;
    chk("lw_release", 32'(ctl()), 32'h0);
    chk("lw_cnt", 32'(stall_cycles), 32'd1);

    // Branch stall on ALU result in E, then decode forwarding from M
    tick();
    branch_D = 1'b1; Rs_D = 5'd7; RegWrite_E = 1'b1; writeReg_E = 5'd7;
    #1;
    chk("br_ctl", 32'(ctl()), 32'b1100100);
    chk("br_fwdA_D_E", 32'(forwardA_D), 32'd0);
    tick();
    RegWrite_E = 1'b0; writeReg_E = 5'd0; RegWrite_M = 1'b1; WriteReg_M = 5'd7;
    #1;
    chk("br_ctl2", 32'(ctl()), 32'h0);
    chk("br_fwdA_D", 32'(forwardA_D), 32'd1);
    chk("br_fwdB_D", 32'(forwardB_D), 32'd0);
    chk("br_cnt", 32'(stall_cycles), 32'd2);

    // Store wait states with a concurrent, masked load-use hazard
    tick();
    clear_inputs();
    MemWrite_M = 1'b1; MemtoReg_E = 1'b1; Rt_E = 5'd4; Rs_D = 5'd4;
    #1;
    chk("sw_ctl0", 32'(ctl()), 32'b1111011);
    tick();
    #1;
    chk("sw_state1", 32'(dbg_state), 32'(ST_WAIT));
    chk("sw_ctl1", 32'(ctl()), 32'b1111011);
    tick();
    #1;
    chk("sw_ctl2", 32'(ctl()), 32'b1100100);
    tick();
    clear_inputs();
    #1;
    chk("sw_ctl3", 32'(ctl()), 32'h0);
    chk("sw_state3", 32'(dbg_state), 32'(ST_IDLE));
    chk("sw_cnt", 32'(stall_cycles), 32'd5);

    // Two back-to-back loads in M
    tick();
    MemtoReg_M = 1'b1; RegWrite_M = 1'b1; WriteReg_M = 5'd8;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("lw2_busy%0d", i), 32'(mem_busy), 32'(pat[i]));
      chk($sformatf("lw2_stallF%0d", i), 32'(stall_F), 32'(pat[i]));
      tick();
    end
    clear_inputs();
    #1;
    chk("lw2_cnt", 32'(stall_cycles), 32'd9);
    chk("lw2_state", 32'(dbg_state), 32'(ST_IDLE));

    // Reset asserted during WAIT, then the access is re-sequenced
    tick();
    MemWrite_M = 1'b1;
    #1;
    chk("rw_busy0", 32'(mem_busy), 32'd1);
    tick();
    #1;
    chk("rw_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("rw_cnt", 32'(stall_cycles), 32'd10);
    RegWrite_M = 1'b1; WriteReg_M = 5'd3; Rs_E = 5'd3;
    #1;
    reset = 1'b0;
    #1;
    chk("rw_rst_ctl", 32'(ctl()), 32'h0);
    chk("rw_rst_fwd", 32'(forwardA_E), 32'(FWD_RF));
    chk("rw_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rw_rst_cnt", 32'(stall_cycles), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("rw_rel_ctl", 32'(ctl()), 32'b1111011);
    chk("rw_rel_fwd", 32'(forwardA_E), 32'(FWD_M));
    tick();
    #1;
    chk("rw_wait_busy", 32'(mem_busy), 32'd1);
    tick();
    #1;
    chk("rw_done_busy", 32'(mem_busy), 32'd0);
    clear_inputs();
    tick();
    #1;
    chk("rw_end_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rw_end_cnt", 32'(stall_cycles), 32'd2);

    // Counter saturation at all-ones (CNT_W = 4)
    MemtoReg_E = 1'b1; Rt_E = 5'd5; Rs_D = 5'd5;
    for (int i = 0; i < 12; i++) tick();
    chk("sat_14", 32'(stall_cycles), 32'd14);
    tick();
    chk("sat_15", 32'(stall_cycles), 32'd15);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_hold", 32'(stall_cycles), 32'd15);
    chk("sat_stallF", 32'(stall_F), 32'd1);
    clear_inputs();
    tick();
    chk("sat_end", 32'(stall_cycles), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
